// File: rtl/rob_queue_pkg.sv
// Shared types for the reorder buffer: the per-entry record and its register-index width.
package rob_queue_pkg;

  localparam int ROB_PREG_W = 6;

  typedef struct packed {
    logic                  valid;
    logic                  completed;
    logic                  is_store;
    logic [ROB_PREG_W-1:0] dest;
    logic [ROB_PREG_W-1:0] old_dest;
    logic [31:0]           data;
  } rob_entry_t;

endpackage

// File: rtl/rob_retire_select.sv
// Prefix scan of up to RETIRE_W slots starting at head: which lanes retire this cycle and how many.
module rob_retire_select #(
  parameter int DEPTH    = 64,
  parameter int RETIRE_W = 2,
  parameter int TAG_W    = $clog2(DEPTH),
  parameter int CNT_W    = $clog2(RETIRE_W + 1)
) (
  input  logic [TAG_W-1:0]          head,
  input  logic [DEPTH-1:0]          slot_ready,
  output logic [CNT_W-1:0]          ret_count,
  output logic [RETIRE_W*TAG_W-1:0] lane_idx,
  output logic [RETIRE_W-1:0]       lane_take
);

  logic [RETIRE_W-1:0] lane_ok;

  generate
    for (genvar gi = 0; gi < RETIRE_W; gi++) begin : g_lane
      assign lane_idx[gi*TAG_W +: TAG_W] = head + TAG_W'(gi);
      assign lane_ok[gi] = slot_ready[lane_idx[gi*TAG_W +: TAG_W]];
    end
  endgenerate

  // A lane retires only if every older lane before it also retires.
  always_comb begin
    logic run;
    lane_take = '0;
    ret_count = '0;
    run       = 1'b1;
    for (int i = 0; i < RETIRE_W; i++) begin
      run          = run & lane_ok[i];
      lane_take[i] = run;
      if (run) ret_count = ret_count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/rob_queue.sv
// Reorder buffer: in-order allocate, out-of-order complete, in-order retire with drain detection.
// Optional macro ROB_FLUSH_EN adds a flush input that empties the buffer.
module rob_queue
  import rob_queue_pkg::*;
#(
  parameter int DEPTH      = 64,
  parameter int DISPATCH_W = 2,
  parameter int RETIRE_W   = 2,
  parameter int NUM_CMP    = 3,
  parameter int PREG_W     = ROB_PREG_W,
  parameter int TAG_W      = $clog2(DEPTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [DISPATCH_W-1:0]        disp_valid,
  input  logic [DISPATCH_W-1:0]        disp_is_store,
  input  logic [DISPATCH_W*PREG_W-1:0] disp_dest,
  input  logic [DISPATCH_W*PREG_W-1:0] disp_old_dest,
  output logic                         disp_ready,
  output logic [DISPATCH_W*TAG_W-1:0]  disp_tag,
  input  logic [NUM_CMP-1:0]           cmp_valid,
  input  logic [NUM_CMP*TAG_W-1:0]     cmp_tag,
  input  logic [NUM_CMP*32-1:0]        cmp_data,
`ifdef ROB_FLUSH_EN
  input  logic                         flush,
`endif
  output logic [RETIRE_W-1:0]          ret_valid,
  output logic [RETIRE_W-1:0]          ret_is_store,
  output logic [RETIRE_W*PREG_W-1:0]   ret_dest,
  output logic [RETIRE_W*32-1:0]       ret_data,
  output logic [RETIRE_W*PREG_W-1:0]   ret_free_reg,
  output logic [TAG_W:0]               occupancy,
  output logic                         full,
  output logic                         empty,
  input  logic                         drain_req,
  output logic                         drained
);

  localparam int OCC_W  = TAG_W + 1;
  localparam int CNT_W  = $clog2(RETIRE_W + 1);
  localparam int DCNT_W = $clog2(DISPATCH_W + 1);

  rob_entry_t                  entries_reg [DEPTH];
  logic [TAG_W-1:0]            head_reg, tail_reg;
  logic [OCC_W-1:0]            occupancy_reg;
  logic                        drain_sticky_reg, drained_reg;
  logic [RETIRE_W-1:0]         ret_valid_reg, ret_is_store_reg;
  logic [RETIRE_W*PREG_W-1:0]  ret_dest_reg, ret_free_reg_reg;
  logic [RETIRE_W*32-1:0]      ret_data_reg;

  logic [DEPTH-1:0]            slot_ready;
  logic [CNT_W-1:0]            ret_count;
  logic [RETIRE_W*TAG_W-1:0]   lane_idx;
  logic [RETIRE_W-1:0]         lane_take;
  rob_entry_t                  ret_entry [RETIRE_W];
  logic                        disp_fire;
  logic [DCNT_W-1:0]           disp_count;

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
      assign slot_ready[gi] = entries_reg[gi].valid & entries_reg[gi].completed;
    end
    for (genvar gi = 0; gi < DISPATCH_W; gi++) begin : g_tag
      assign disp_tag[gi*TAG_W +: TAG_W] = tail_reg + TAG_W'(gi);
    end
  endgenerate

  rob_retire_select #(
    .DEPTH    (DEPTH),
    .RETIRE_W (RETIRE_W),
    .TAG_W    (TAG_W),
    .CNT_W    (CNT_W)
  ) u_retire_select (
    .head       (head_reg),
    .slot_ready (slot_ready),
    .ret_count  (ret_count),
    .lane_idx   (lane_idx),
    .lane_take  (lane_take)
  );

  assign disp_ready   = (occupancy_reg <= OCC_W'(DEPTH - DISPATCH_W));
  assign occupancy    = occupancy_reg;
  assign full         = (occupancy_reg == OCC_W'(DEPTH));
  assign empty        = (occupancy_reg == '0);
  assign drained      = drained_reg;
  assign ret_valid    = ret_valid_reg;
  assign ret_is_store = ret_is_store_reg;
  assign ret_dest     = ret_dest_reg;
  assign ret_data     = ret_data_reg;
  assign ret_free_reg = ret_free_reg_reg;

  always_comb begin
    disp_fire  = disp_ready & disp_valid[0];
    disp_count = '0;
    for (int i = 0; i < DISPATCH_W; i++) begin
      if (disp_fire && disp_valid[i]) disp_count = disp_count + DCNT_W'(1);
    end
    for (int k = 0; k < RETIRE_W; k++) begin
      ret_entry[k] = entries_reg[lane_idx[k*TAG_W +: TAG_W]];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_reg         <= '0;
      tail_reg         <= '0;
      occupancy_reg    <= '0;
      drain_sticky_reg <= 1'b0;
      drained_reg      <= 1'b0;
      ret_valid_reg    <= '0;
      ret_is_store_reg <= '0;
      ret_dest_reg     <= '0;
      ret_data_reg     <= '0;
      ret_free_reg_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        entries_reg[i].valid     <= 1'b0;
        entries_reg[i].completed <= 1'b0;
      end
    end else begin
      drain_sticky_reg <= drain_sticky_reg | drain_req;
      if ((occupancy_reg == '0) && (drain_sticky_reg | drain_req) && !disp_fire)
        drained_reg <= 1'b1;
`ifdef ROB_FLUSH_EN
      if (flush) begin
        for (int i = 0; i < DEPTH; i++) begin
          entries_reg[i].valid     <= 1'b0;
          entries_reg[i].completed <= 1'b0;
        end
        tail_reg         <= head_reg;
        occupancy_reg    <= '0;
        ret_valid_reg    <= '0;
        ret_is_store_reg <= '0;
        ret_dest_reg     <= '0;
        ret_data_reg     <= '0;
        ret_free_reg_reg <= '0;
      end else
`endif
      begin
        // Highest port first so the lowest index is the last write and wins on duplicates.
        for (int p = NUM_CMP - 1; p >= 0; p--) begin
          if (cmp_valid[p] && entries_reg[cmp_tag[p*TAG_W +: TAG_W]].valid) begin
            entries_reg[cmp_tag[p*TAG_W +: TAG_W]].completed <= 1'b1;
            entries_reg[cmp_tag[p*TAG_W +: TAG_W]].data      <= cmp_data[p*32 +: 32];
          end
        end

        for (int k = 0; k < RETIRE_W; k++) begin
          if (lane_take[k]) begin
            entries_reg[lane_idx[k*TAG_W +: TAG_W]].valid     <= 1'b0;
            entries_reg[lane_idx[k*TAG_W +: TAG_W]].completed <= 1'b0;
          end
          ret_valid_reg[k]    <= lane_take[k];
          ret_is_store_reg[k] <= lane_take[k] & ret_entry[k].is_store;
          ret_dest_reg[k*PREG_W +: PREG_W] <=
            lane_take[k] ? PREG_W'(ret_entry[k].dest) : '0;
          ret_data_reg[k*32 +: 32] <= lane_take[k] ? ret_entry[k].data : '0;
          // Stores never rename a destination, so they free nothing.
          ret_free_reg_reg[k*PREG_W +: PREG_W] <=
            (lane_take[k] && !ret_entry[k].is_store) ? PREG_W'(ret_entry[k].old_dest) : '0;
        end

        // Dispatch targets only free slots, so it never collides with the retire clears above.
        for (int i = 0; i < DISPATCH_W; i++) begin
          if (disp_fire && disp_valid[i]) begin
            entries_reg[tail_reg + TAG_W'(i)] <= '{
              valid:     1'b1,
              completed: 1'b0,
              is_store:  disp_is_store[i],
              dest:      ROB_PREG_W'(disp_dest[i*PREG_W +: PREG_W]),
              old_dest:  ROB_PREG_W'(disp_old_dest[i*PREG_W +: PREG_W]),
              data:      '0
            };
          end
        end

        head_reg      <= head_reg + TAG_W'(ret_count);
        tail_reg      <= tail_reg + TAG_W'(disp_count);
        occupancy_reg <= occupancy_reg + OCC_W'(disp_count) - OCC_W'(ret_count);
      end
    end
  end

endmodule

// File: tb/tb_rob_queue.sv
// Directed testbench for rob_queue at DEPTH=8, DISPATCH_W=2, RETIRE_W=2, NUM_CMP=3.
module tb_rob_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  disp_valid, disp_is_store;
  logic [11:0] disp_dest, disp_old_dest;
  logic        disp_ready;
  logic [5:0]  disp_tag;
  logic [2:0]  cmp_valid;
  logic [8:0]  cmp_tag;
  logic [95:0] cmp_data;
`ifdef ROB_FLUSH_EN
  logic        flush;
`endif
  logic [1:0]  ret_valid, ret_is_store;
  logic [11:0] ret_dest, ret_free_reg;
  logic [63:0] ret_data;
  logic [3:0]  occupancy;
  logic        full, empty, drain_req, drained;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  rob_queue #(
    .DEPTH(8), .DISPATCH_W(2), .RETIRE_W(2), .NUM_CMP(3), .PREG_W(6)
  ) dut (
    .clk(clk), .rst(rst),
    .disp_valid(disp_valid), .disp_is_store(disp_is_store),
    .disp_dest(disp_dest), .disp_old_dest(disp_old_dest),
    .disp_ready(disp_ready), .disp_tag(disp_tag),
    .cmp_valid(cmp_valid), .cmp_tag(cmp_tag), .cmp_data(cmp_data),
`ifdef ROB_FLUSH_EN
    .flush(flush),
`endif
    .ret_valid(ret_valid), .ret_is_store(ret_is_store), .ret_dest(ret_dest),
    .ret_data(ret_data), .ret_free_reg(ret_free_reg),
    .occupancy(occupancy), .full(full), .empty(empty),
    .drain_req(drain_req), .drained(drained)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    disp_valid = '0; disp_is_store = '0; disp_dest = '0; disp_old_dest = '0;
    cmp_valid = '0; cmp_tag = '0; cmp_data = '0; drain_req = 1'b0;
`ifdef ROB_FLUSH_EN
    flush = 1'b0;
`endif
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic dispatch(input logic [1:0] v, input logic [1:0] st,
                          input logic [11:0] dst, input logic [11:0] old);
    disp_valid = v; disp_is_store = st; disp_dest = dst; disp_old_dest = old;
    tick();
    disp_valid = '0; disp_is_store = '0;
  endtask

  task automatic complete(input logic [2:0] v, input logic [8:0] tags, input logic [95:0] data);
    cmp_valid = v; cmp_tag = tags; cmp_data = data;
    tick();
    cmp_valid = '0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL reset_occupancy got=%0d exp=0", occupancy); end
    n_cmp++; if (empty !== 1'b1) begin n_fail++; $display("FAIL reset_empty got=%b exp=1", empty); end
    n_cmp++; if (full !== 1'b0) begin n_fail++; $display("FAIL reset_full got=%b exp=0", full); end
    n_cmp++; if (disp_ready !== 1'b1) begin n_fail++; $display("FAIL reset_disp_ready got=%b exp=1", disp_ready); end
    n_cmp++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL reset_ret_valid got=%b exp=00", ret_valid); end
    n_cmp++; if (drained !== 1'b0) begin n_fail++; $display("FAIL reset_drained got=%b exp=0", drained); end
    n_cmp++; if (disp_tag !== 6'b001_000) begin n_fail++; $display("FAIL reset_disp_tag got=%b exp=001000", disp_tag); end
    $display("test_reset done");
  endtask

  task automatic test_basic();
    dispatch(2'b11, 2'b00, {6'd6, 6'd5}, {6'd2, 6'd1});
    n_cmp++; if (occupancy !== 4'd2) begin n_fail++; $display("FAIL basic_occ got=%0d exp=2", occupancy); end
    n_cmp++; if (empty !== 1'b0) begin n_fail++; $display("FAIL basic_empty got=%b exp=0", empty); end
    complete(3'b001, {3'd0, 3'd0, 3'd1}, {32'h0, 32'h0, 32'h22});
    n_cmp++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL basic_no_early_retire got=%b exp=00", ret_valid); end
    complete(3'b001, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h11});
    n_cmp++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL basic_no_bypass got=%b exp=00", ret_valid); end
    tick();
    n_cmp++; if (ret_valid !== 2'b11) begin n_fail++; $display("FAIL basic_ret_valid got=%b exp=11", ret_valid); end
    n_cmp++; if (ret_data !== {32'h22, 32'h11}) begin n_fail++; $display("FAIL basic_ret_data got=%h exp=%h", ret_data, {32'h22, 32'h11}); end
    n_cmp++; if (ret_free_reg !== {6'd2, 6'd1}) begin n_fail++; $display("FAIL basic_free_reg got=%h exp=%h", ret_free_reg, {6'd2, 6'd1}); end
    n_cmp++; if (ret_dest !== {6'd6, 6'd5}) begin n_fail++; $display("FAIL basic_ret_dest got=%h exp=%h", ret_dest, {6'd6, 6'd5}); end
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL basic_occ_after got=%0d exp=0", occupancy); end
    tick();
    n_cmp++; if (ret_valid !== 2'b00 || ret_data !== 64'h0) begin n_fail++; $display("FAIL basic_idle_ret got=%b/%h exp=00/0", ret_valid, ret_data); end
    $display("test_basic done");
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 3; i++) dispatch(2'b11, 2'b00, {6'd3, 6'd4}, {6'd7, 6'd8});
    n_cmp++; if (occupancy !== 4'd6 || disp_ready !== 1'b1) begin n_fail++; $display("FAIL full_occ6 got=%0d/%b exp=6/1", occupancy, disp_ready); end
    dispatch(2'b01, 2'b00, {6'd0, 6'd9}, {6'd0, 6'd9});
    n_cmp++; if (occupancy !== 4'd7) begin n_fail++; $display("FAIL full_occ7 got=%0d exp=7", occupancy); end
    n_cmp++; if (disp_ready !== 1'b0 || full !== 1'b0) begin n_fail++; $display("FAIL full_ready7 got=%b/%b exp=0/0", disp_ready, full); end
    n_cmp++; if (disp_tag !== {3'd0, 3'd7}) begin n_fail++; $display("FAIL full_tag7 got=%b exp=000111", disp_tag); end
    dispatch(2'b11, 2'b00, {6'd1, 6'd1}, {6'd1, 6'd1});
    n_cmp++; if (occupancy !== 4'd7 || disp_tag !== {3'd0, 3'd7}) begin n_fail++; $display("FAIL full_ignored got=%0d/%b exp=7/000111", occupancy, disp_tag); end
    do_reset();
    for (int i = 0; i < 4; i++) dispatch(2'b11, 2'b00, {6'd3, 6'd4}, {6'd7, 6'd8});
    n_cmp++; if (occupancy !== 4'd8 || full !== 1'b1 || disp_ready !== 1'b0 || empty !== 1'b0) begin
      n_fail++; $display("FAIL full_occ8 got=%0d/%b/%b/%b exp=8/1/0/0", occupancy, full, disp_ready, empty); end
    $display("test_full done");
  endtask

  task automatic test_wrap();
    do_reset();
    for (int i = 0; i < 3; i++) dispatch(2'b11, 2'b00, {6'd1, 6'd1}, {6'd1, 6'd1});
    complete(3'b111, {3'd2, 3'd1, 3'd0}, {32'h2, 32'h1, 32'h0});
    complete(3'b111, {3'd5, 3'd4, 3'd3}, {32'h5, 32'h4, 32'h3});
    for (int i = 0; i < 10 && occupancy !== 4'd0; i++) tick();
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL wrap_drain_timeout got=%0d exp=0", occupancy); end
    n_cmp++; if (disp_tag !== {3'd7, 3'd6}) begin n_fail++; $display("FAIL wrap_tag67 got=%b exp=111110", disp_tag); end
    dispatch(2'b11, 2'b00, {6'd21, 6'd20}, {6'd11, 6'd10});
    n_cmp++; if (disp_tag !== {3'd1, 3'd0}) begin n_fail++; $display("FAIL wrap_tag01 got=%b exp=001000", disp_tag); end
    dispatch(2'b11, 2'b00, {6'd23, 6'd22}, {6'd13, 6'd12});
    n_cmp++; if (occupancy !== 4'd4) begin n_fail++; $display("FAIL wrap_occ4 got=%0d exp=4", occupancy); end
    complete(3'b111, {3'd0, 3'd7, 3'd6}, {32'h80, 32'h70, 32'h60});
    complete(3'b001, {3'd0, 3'd0, 3'd1}, {32'h0, 32'h0, 32'h90});
    n_cmp++; if (ret_valid !== 2'b11 || ret_dest !== {6'd21, 6'd20} || ret_data !== {32'h70, 32'h60}) begin
      n_fail++; $display("FAIL wrap_ret67 got=%b/%h/%h exp=11/%h/%h", ret_valid, ret_dest, ret_data, {6'd21, 6'd20}, {32'h70, 32'h60}); end
    tick();
    n_cmp++; if (ret_valid !== 2'b11 || ret_dest !== {6'd23, 6'd22} || ret_data !== {32'h90, 32'h80} || ret_free_reg !== {6'd13, 6'd12}) begin
      n_fail++; $display("FAIL wrap_ret01 got=%b/%h/%h/%h exp=11/%h/%h/%h", ret_valid, ret_dest, ret_data, ret_free_reg,
                         {6'd23, 6'd22}, {32'h90, 32'h80}, {6'd13, 6'd12}); end
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL wrap_occ0 got=%0d exp=0", occupancy); end
    $display("test_wrap done");
  endtask

  task automatic test_store();
    do_reset();
    dispatch(2'b01, 2'b01, {6'd0, 6'd9}, {6'd0, 6'd7});
    complete(3'b001, {3'd0, 3'd0, 3'd0}, {32'h0, 32'h0, 32'h40});
    tick();
    n_cmp++; if (ret_valid !== 2'b01 || ret_is_store !== 2'b01) begin n_fail++; $display("FAIL store_valid got=%b/%b exp=01/01", ret_valid, ret_is_store); end
    n_cmp++; if (ret_dest !== {6'd0, 6'd9} || ret_data !== {32'h0, 32'h40}) begin n_fail++; $display("FAIL store_fields got=%h/%h exp=009/40", ret_dest, ret_data); end
    n_cmp++; if (ret_free_reg !== 12'h0) begin n_fail++; $display("FAIL store_free_reg got=%h exp=0", ret_free_reg); end
    $display("test_store done");
  endtask

  task automatic test_dup();
    do_reset();
    dispatch(2'b11, 2'b00, {6'd2, 6'd1}, {6'd1, 6'd1});
    dispatch(2'b11, 2'b00, {6'd4, 6'd3}, {6'd1, 6'd1});
    complete(3'b111, {3'd3, 3'd5, 3'd3}, {32'hB, 32'hFF, 32'hA});
    n_cmp++; if (occupancy !== 4'd4 || ret_valid !== 2'b00) begin n_fail++; $display("FAIL dup_occ got=%0d/%b exp=4/00", occupancy, ret_valid); end
    complete(3'b111, {3'd2, 3'd1, 3'd0}, {32'hC2, 32'hC1, 32'hC0});
    tick();
    n_cmp++; if (ret_data !== {32'hC1, 32'hC0}) begin n_fail++; $display("FAIL dup_ret01 got=%h exp=%h", ret_data, {32'hC1, 32'hC0}); end
    tick();
    n_cmp++; if (ret_valid !== 2'b11 || ret_data !== {32'hA, 32'hC2}) begin n_fail++; $display("FAIL dup_low_port_wins got=%b/%h exp=11/%h", ret_valid, ret_data, {32'hA, 32'hC2}); end
    n_cmp++; if (occupancy !== 4'd0) begin n_fail++; $display("FAIL dup_occ0 got=%0d exp=0", occupancy); end
    $display("test_dup done");
  endtask

  task automatic test_drain();
    do_reset();
    dispatch(2'b11, 2'b00, {6'd2, 6'd1}, {6'd4, 6'd3});
    drain_req = 1'b1;
    tick();
    drain_req = 1'b0;
    n_cmp++; if (drained !== 1'b0) begin n_fail++; $display("FAIL drain_pending got=%b exp=0", drained); end
    complete(3'b011, {3'd0, 3'd1, 3'd0}, {32'h0, 32'h2, 32'h1});
    n_cmp++; if (drained !== 1'b0 || occupancy !== 4'd2) begin n_fail++; $display("FAIL drain_cmp got=%b/%0d exp=0/2", drained, occupancy); end
    tick();
    n_cmp++; if (drained !== 1'b0 || occupancy !== 4'd0) begin n_fail++; $display("FAIL drain_retire got=%b/%0d exp=0/0", drained, occupancy); end
    tick();
    n_cmp++; if (drained !== 1'b1) begin n_fail++; $display("FAIL drain_set got=%b exp=1", drained); end
    dispatch(2'b01, 2'b00, {6'd0, 6'd5}, {6'd0, 6'd6});
    tick();
    n_cmp++; if (drained !== 1'b1) begin n_fail++; $display("FAIL drain_sticky got=%b exp=1", drained); end
    $display("test_drain done");
  endtask

`ifdef ROB_FLUSH_EN
  task automatic test_flush();
    do_reset();
    dispatch(2'b11, 2'b00, {6'd2, 6'd1}, {6'd4, 6'd3});
    dispatch(2'b11, 2'b00, {6'd2, 6'd1}, {6'd4, 6'd3});
    dispatch(2'b01, 2'b00, {6'd0, 6'd1}, {6'd0, 6'd3});
    n_cmp++; if (occupancy !== 4'd5) begin n_fail++; $display("FAIL flush_occ5 got=%0d exp=5", occupancy); end
    flush = 1'b1;
    disp_valid = 2'b11;
    cmp_valid = 3'b011; cmp_tag = {3'd0, 3'd1, 3'd0}; cmp_data = {32'h0, 32'h2, 32'h1};
    tick();
    clear_inputs();
    n_cmp++; if (occupancy !== 4'd0 || empty !== 1'b1) begin n_fail++; $display("FAIL flush_empty got=%0d/%b exp=0/1", occupancy, empty); end
    n_cmp++; if (ret_valid !== 2'b00 || disp_tag !== {3'd1, 3'd0}) begin n_fail++; $display("FAIL flush_state got=%b/%b exp=00/001000", ret_valid, disp_tag); end
    tick();
    n_cmp++; if (ret_valid !== 2'b00) begin n_fail++; $display("FAIL flush_no_retire got=%b exp=00", ret_valid); end
    $display("test_flush done");
  endtask
`endif

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_basic();
    test_full();
    test_wrap();
    test_store();
    test_dup();
    test_drain();
`ifdef ROB_FLUSH_EN
    test_flush();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_queue.md
Name: rob_queue

Overview:
- Parametrised reorder buffer that generalises the combined dispatch/ROB logic to configurable depth, dispatch width, retire width and completion-port count.
- Sits between Rename/dispatch and the register-file/memory commit path.
- Allocates in-order tags, accepts out-of-order completions from FUs, and retires in order.
- Emits register-commit, store-commit and physical-register-free information, with explicit full/empty flow control and drain detection.

Parameters:
- DEPTH, 64, entries; power of two, at least 4.
- DISPATCH_W, 2, dispatch lanes per cycle (1..4).
- RETIRE_W, 2, retire lanes per cycle (1..4).
- NUM_CMP, 3, completion ports (one per FU).
- PREG_W, 6, physical register index width.
- TAG_W, $clog2(DEPTH), tag width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- disp_valid  in  DISPATCH_W  per-lane dispatch request; lanes must be a prefix (lane i set implies lanes below i set)
- disp_is_store  in  DISPATCH_W  lane carries sw
- disp_dest  in  DISPATCH_W*PREG_W  p_rd; for a store, p_rs2 (the data register)
- disp_old_dest  in  DISPATCH_W*PREG_W  previous mapping of rd
- disp_ready  out  1  combinational; high when free slots >= DISPATCH_W
- disp_tag  out  DISPATCH_W*TAG_W  combinational; lane k tag = tail+k
- cmp_valid  in  NUM_CMP  completion strobe
- cmp_tag  in  NUM_CMP*TAG_W  completing tag
- cmp_data  in  NUM_CMP*32  result, or effective address for a store
- ret_valid  out  RETIRE_W  registered; a prefix
- ret_is_store  out  RETIRE_W
- ret_dest  out  RETIRE_W*PREG_W
- ret_data  out  RETIRE_W*32
- ret_free_reg  out  RETIRE_W*PREG_W  old_dest; 0 for stores
- occupancy  out  TAG_W+1  registered entry count
- full, empty  out  1  combinational from occupancy
- drain_req  in  1  fetch finished; sticky once sampled high
- drained  out  1  registered

Behaviour:
- Entry fields: valid, completed, is_store, dest, old_dest, data[31:0].
- Reset: head=tail=0, occupancy=0, every valid/completed cleared, all ret_* = 0, drained=0, drain sticky cleared. Reset mid-operation discards all entries without emitting retires.
- Dispatch:
  - Fires when disp_ready and disp_valid[0]. All valid lanes are accepted together; there is no partial acceptance.
  - Each accepted entry: valid=1, completed=0. tail += number of accepted lanes, modulo DEPTH (natural wrap).
  - When disp_ready=0, nothing is accepted and upstream holds.
- Completion:
  - On the edge: if entry[cmp_tag].valid, set completed=1 and data=cmp_data. Completions to invalid tags are ignored.
  - Duplicate tags in one cycle: the lowest port index wins.
  - A completion sets the bit visible from the next cycle; no same-cycle completion-to-retire bypass.
- Retire:
  - n = count of consecutive valid&&completed entries from head, capped at RETIRE_W.
  - Lane k outputs entry head+k (wrapping); valid cleared; head += n. ret_* are registered, appearing the cycle after retire is decided.
  - Lanes >= n: ret_valid=0, all other ret_* fields 0.
  - ret_dest=0 on a non-store means no regfile write; downstream checks this.
- Occupancy:
  - Next occupancy = occupancy + accepted - n; dispatch and retire in the same cycle are legal.
  - full when occupancy > DEPTH-DISPATCH_W is false for disp_ready purposes. full itself = (occupancy==DEPTH); empty = (occupancy==0).
- Drain: drained goes high the cycle after occupancy==0, sticky drain_req=1 and no dispatch. It stays high until rst.
- Latency: dispatch edge E, completion edge >= E+1, earliest retire output valid after edge E+2.

Optional Feature:
- ROB_FLUSH_EN
- When defined, adds input flush (1 bit), which has priority over everything else. On a flush edge:
  - all valid/completed bits are cleared;
  - tail=head;
  - occupancy=0;
  - same-cycle dispatch and completions are dropped;
  - ret_valid=0 next cycle; drained is unaffected.
- When undefined, the port and its logic are absent.

Decomposition:
- Add rob_entry_t (struct of the entry fields) to RSTableROBStruct; sw/lw opcodes stay in instructionList.
- One sub-module, rob_retire_select: combinational prefix scan of the RETIRE_W slots from head, outputting n and per-lane indices.

Test Plan (DEPTH=8, DISPATCH_W=2, RETIRE_W=2, NUM_CMP=3):
- Reset, then dispatch lanes {dest 5/old 1, dest 6/old 2} -> tags 0,1; occupancy=2. Complete tag1=0x22, then tag0=0x11 -> next cycle ret_valid=2'b11, ret_data 0x11/0x22, ret_free_reg 1/2.
- Fill 8 entries -> disp_ready=0 at occupancy 7, full=1 at 8. Further disp_valid is ignored and tags do not advance.
- Wrap: head=tail=6, dispatch 4 entries -> tags 6,7,0,1. Complete all -> retire order 6,7,0,1 over two cycles.
- Store at tag0 (dest 9, address 0x40 via completion) -> ret_is_store=1, ret_dest=9, ret_data=0x40, ret_free_reg=0.
- Completion on cmp ports 0 and 2 with the same tag 3 (0xA, 0xB) -> data 0xA. Completion to an empty tag is ignored; occupancy is unchanged.
- drain_req pulse with 2 entries pending -> drained stays 0 until both retire, then 1 the following cycle. With ROB_FLUSH_EN, flush at occupancy 5 -> occupancy 0 and empty next cycle.
